// File: rtl/sbox_cfg_loader.sv
// rtl/sbox_cfg_loader.sv - streams 4-bit S-box entries into addressed write strobes
// Full 8x64 table load or single-box reload, with idle timeout and abort.
module sbox_cfg_loader #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mode_all,
   input  logic [2:0] start_box,
   input  logic       abort,
   input  logic       in_valid,
   input  logic [3:0] in_data,
   output logic       in_ready,
   output logic       edit_sbox,
   output logic [3:0] new_sbox_val,
   output logic [2:0] sbox_sel,
   output logic [1:0] row_sel,
   output logic [3:0] col_sel,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   // Counter value seen on the last idle cycle before the timeout fires.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

   state_t          state, state_nxt;
   logic [8:0]      idx, idx_nxt;
   logic [8:0]      last_idx, last_idx_nxt;
   logic [TO_W-1:0] to_cnt, to_cnt_nxt;
   logic            accept;

   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx;
      last_idx_nxt = last_idx;
      to_cnt_nxt   = to_cnt;
      in_ready     = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      err          = 1'b0;
      accept       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt    = LOAD;
               idx_nxt      = {(mode_all ? 3'd0 : start_box), 6'd0};
               last_idx_nxt = mode_all ? 9'd511 : {start_box, 6'd63};
               to_cnt_nxt   = '0;
            end
         end
         LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            accept   = in_valid;
            if (accept) begin
               to_cnt_nxt = '0;
               if (idx == last_idx) begin
                  state_nxt = DONE;
               end else begin
                  idx_nxt = idx + 9'd1;
               end
            end else if (to_cnt == TO_LAST) begin
               state_nxt = ERR;
            end else begin
               to_cnt_nxt = to_cnt + TO_ONE;
            end
            // Abort wins over completion and timeout; the accepted word is still written.
            if (abort) begin
               state_nxt = IDLE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         ERR: begin
            err       = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         idx          <= '0;
         last_idx     <= '0;
         to_cnt       <= '0;
         edit_sbox    <= 1'b0;
         new_sbox_val <= '0;
         sbox_sel     <= '0;
         row_sel      <= '0;
         col_sel      <= '0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         last_idx  <= last_idx_nxt;
         to_cnt    <= to_cnt_nxt;
         edit_sbox <= accept;
         // Address/data hold between strobes so the bank sees a stable bus.
         if (accept) begin
            new_sbox_val <= in_data;
            sbox_sel     <= idx[8:6];
            row_sel      <= idx[5:4];
            col_sel      <= idx[3:0];
         end
      end
   end

endmodule

// File: tb/tb_sbox_cfg_loader.sv
// tb/tb_sbox_cfg_loader.sv - self-checking bench for sbox_cfg_loader
module tb_sbox_cfg_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       mode_all = 1'b0;
   logic [2:0] start_box = 3'd0;
   logic       abort = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = 4'd0;
   logic       in_ready;
   logic       edit_sbox;
   logic [3:0] new_sbox_val;
   logic [2:0] sbox_sel;
   logic [1:0] row_sel;
   logic [3:0] col_sel;
   logic       busy;
   logic       done;
   logic       err;

   sbox_cfg_loader #(.TIMEOUT_CYCLES(10), .TO_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .mode_all(mode_all),
      .start_box(start_box), .abort(abort), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .edit_sbox(edit_sbox),
      .new_sbox_val(new_sbox_val), .sbox_sel(sbox_sel), .row_sel(row_sel),
      .col_sel(col_sel), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [3:0] val;
      logic [8:0] addr;
   } strb_t;

   typedef struct {
      int         k;
      logic [2:0] sel;
      logic [1:0] row;
      logic [3:0] col;
      logic [3:0] val;
   } vec_t;

   int         cyc = 0;
   strb_t      strb_q[$];
   int         acc_q[$];
   int         done_q[$];
   int         err_q[$];
   int         busy_cnt = 0;
   logic [3:0] bank [512];
   int         n_chk = 0;
   int         n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Passive bus monitor and S-box bank model.
   always @(negedge clk) begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (edit_sbox) begin
         strb_q.push_back('{cyc, new_sbox_val, {sbox_sel, row_sel, col_sel}});
         bank[{sbox_sel, row_sel, col_sel}] = new_sbox_val;
      end
      if (done) done_q.push_back(cyc);
      if (err) err_q.push_back(cyc);
      if (busy) busy_cnt++;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int outs();
      return int'({in_ready, edit_sbox, new_sbox_val, sbox_sel, row_sel, col_sel, busy, done, err});
   endfunction

   task automatic do_start(input logic all, input logic [2:0] box);
      @(posedge clk); #1;
      start = 1'b1; mode_all = all; start_box = box;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_stream(input int nwords, input bit toggle, input int abort_at,
                             input int stop_after, input int restart_at, input int budget);
      int n = 0;
      bit phase = 1'b0;
      for (int t = 0; t < budget && n < nwords; t++) begin
         in_valid = (n < stop_after) && (!toggle || !phase);
         in_data  = 4'(n % 16);
         abort    = (abort_at != 0) && in_valid && in_ready && (n + 1 == abort_at);
         start    = (restart_at != 0) && (n == restart_at);
         if (start) start_box = 3'd5;
         if (in_valid && in_ready) n++;
         phase = ~phase;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; abort = 1'b0; start = 1'b0;
   endtask

   // Every strobe i addresses base+i, carries word i%16 and trails its accept by one cycle.
   task automatic check_order(input string name, input int s0, input int a0, input int n, input int base);
      int bad = 0;
      if (strb_q.size() < s0 + n || acc_q.size() < a0 + n) begin
         bad = -1;
      end else begin
         for (int i = 0; i < n; i++) begin
            if (strb_q[s0+i].addr != 9'(base + i)) bad++;
            if (strb_q[s0+i].val != 4'(i % 16)) bad++;
            if (strb_q[s0+i].cyc != acc_q[a0+i] + 1) bad++;
         end
      end
      chk(name, bad, 0);
   endtask

   initial begin
      vec_t vecs[6];
      int s0, a0, d0, e0, b0, bad;
      vecs[0] = '{0,   3'd0, 2'd0, 4'd0,  4'd0};
      vecs[1] = '{17,  3'd0, 2'd1, 4'd1,  4'd1};
      vecs[2] = '{63,  3'd0, 2'd3, 4'd15, 4'd15};
      vecs[3] = '{64,  3'd1, 2'd0, 4'd0,  4'd0};
      vecs[4] = '{300, 3'd4, 2'd2, 4'd12, 4'd12};
      vecs[5] = '{511, 3'd7, 2'd3, 4'd15, 4'd15};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs_in_rst", outs(), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("reset_outs_after", outs(), 0);

      // Full 8x64 load, in_valid held high.
      s0 = strb_q.size(); a0 = acc_q.size(); d0 = done_q.size(); e0 = err_q.size();
      do_start(1'b1, 3'd0);
      run_stream(512, 1'b0, 0, 512, 0, 600);
      repeat (3) @(posedge clk);
      #1;
      chk("full_strobes", strb_q.size() - s0, 512);
      check_order("full_order", s0, a0, 512, 0);
      for (int v = 0; v < 6; v++) begin
         if (strb_q.size() > s0 + vecs[v].k)
            chk($sformatf("full_vec_k%0d", vecs[v].k),
                int'({strb_q[s0+vecs[v].k].addr, strb_q[s0+vecs[v].k].val}),
                int'({vecs[v].sel, vecs[v].row, vecs[v].col, vecs[v].val}));
         else
            chk($sformatf("full_vec_k%0d", vecs[v].k), -1, vecs[v].k);
      end
      chk("full_done_cnt", done_q.size() - d0, 1);
      chk("full_done_cyc", (done_q.size() > d0 && strb_q.size() >= s0 + 512) ?
          done_q[d0] - strb_q[s0+511].cyc : -99, 0);
      chk("full_err_cnt", err_q.size() - e0, 0);
      chk("full_bank_7_3_5", int'(bank[{3'd7, 2'd3, 4'd5}]), 5);
      chk("full_idle_ready", int'({in_ready, busy}), 0);

      // Single box 3 with in_valid toggling every cycle.
      s0 = strb_q.size(); a0 = acc_q.size(); d0 = done_q.size(); b0 = busy_cnt;
      do_start(1'b0, 3'd3);
      run_stream(64, 1'b1, 0, 64, 0, 200);
      repeat (3) @(posedge clk);
      #1;
      chk("box3_strobes", strb_q.size() - s0, 64);
      check_order("box3_order", s0, a0, 64, 3 * 64);
      bad = 0;
      for (int i = s0 + 1; i < strb_q.size(); i++)
         if (strb_q[i].cyc - strb_q[i-1].cyc != 2) bad++;
      chk("box3_spacing", bad, 0);
      chk("box3_done_cnt", done_q.size() - d0, 1);
      chk("box3_done_cyc", (done_q.size() > d0 && strb_q.size() > s0) ?
          done_q[d0] - strb_q[strb_q.size()-1].cyc : -99, 0);
      chk("box3_busy_cycles", busy_cnt - b0, 127);

      // Timeout: 5 words into box 0, then silence.
      s0 = strb_q.size(); a0 = acc_q.size(); d0 = done_q.size(); e0 = err_q.size();
      do_start(1'b0, 3'd0);
      run_stream(64, 1'b0, 0, 5, 0, 40);
      #1;
      chk("to_strobes", strb_q.size() - s0, 5);
      chk("to_err_cnt", err_q.size() - e0, 1);
      chk("to_err_cyc", (err_q.size() > e0 && acc_q.size() >= a0 + 5) ?
          err_q[e0] - acc_q[a0+4] : -99, 11);
      chk("to_done_cnt", done_q.size() - d0, 0);
      chk("to_idle", int'({in_ready, busy}), 0);

      // Abort on the 20th accept of a full load.
      s0 = strb_q.size(); a0 = acc_q.size(); d0 = done_q.size(); e0 = err_q.size();
      do_start(1'b1, 3'd0);
      run_stream(512, 1'b0, 20, 512, 0, 40);
      #1;
      chk("abort_strobes", strb_q.size() - s0, 20);
      check_order("abort_order", s0, a0, 20, 0);
      chk("abort_idle", int'({in_ready, busy}), 0);
      chk("abort_done_err", (done_q.size() - d0) + (err_q.size() - e0), 0);

      // Second start during box 2 load must be ignored.
      s0 = strb_q.size(); a0 = acc_q.size(); d0 = done_q.size();
      do_start(1'b0, 3'd2);
      run_stream(64, 1'b0, 0, 64, 10, 100);
      repeat (3) @(posedge clk);
      #1;
      chk("restart_strobes", strb_q.size() - s0, 64);
      check_order("restart_order", s0, a0, 64, 2 * 64);
      chk("restart_done_cnt", done_q.size() - d0, 1);

      // Reset after 30 accepts of a full load.
      s0 = strb_q.size(); a0 = acc_q.size(); d0 = done_q.size(); e0 = err_q.size();
      do_start(1'b1, 3'd0);
      run_stream(512, 1'b0, 0, 30, 0, 30);
      rst = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_outs", outs(), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("rst_mid_strobes", strb_q.size() - s0, 30);
      check_order("rst_mid_order", s0, a0, 30, 0);
      chk("rst_mid_idle", int'({in_ready, busy}), 0);
      chk("rst_mid_done_err", (done_q.size() - d0) + (err_q.size() - e0), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
